// File: rtl/low_freq_gen_if.sv
// Control/status bundle for the low-frequency square-wave generator.
// The master drives the BCD frequency and start/stop; the slave returns the wave and status.
interface low_freq_gen_if;
  logic        start;
  logic        stop;
  logic [3:0]  bcd3;
  logic [3:0]  bcd2;
  logic [3:0]  bcd1;
  logic [3:0]  bcd0;
  logic        sq_out;
  logic [19:0] prd;
  logic        ready;
  logic        done_tick;
  logic        err;

  modport master (
    output start, stop, bcd3, bcd2, bcd1, bcd0,
    input  sq_out, prd, ready, done_tick, err
  );

  modport slave (
    input  start, stop, bcd3, bcd2, bcd1, bcd0,
    output sq_out, prd, ready, done_tick, err
  );
endinterface

// File: rtl/low_freq_gen.sv
// Square-wave generator: 4-digit BCD frequency -> binary -> period (DVND/freq us),
// then a 50% duty wave whose half period is counted in microsecond ticks.
module low_freq_gen #(
  parameter int US_TICKS = 50,
  parameter int DVND     = 1_000_000
) (
  input  logic          clk,
  input  logic          reset,
  low_freq_gen_if.slave bus
);

  localparam int PW = (US_TICKS > 1) ? $clog2(US_TICKS) : 1;
  localparam logic [19:0] DVND_W = 20'(DVND);

  typedef enum logic [1:0] {IDLE, CONV, DIV, RUN} state_t;

  state_t         state_reg, state_next;
  logic [15:0]    digits_reg, digits_next;
  logic [13:0]    bin_reg, bin_next;
  logic [4:0]     cnt_reg, cnt_next;
  logic [14:0]    rem_reg, rem_next;
  logic [19:0]    quo_reg, quo_next;
  logic [19:0]    prd_reg, prd_next;
  logic [18:0]    half_reg, half_next;
  logic [PW-1:0]  us_reg, us_next;
  logic [18:0]    hcnt_reg, hcnt_next;
  logic           sq_reg, sq_next;
  logic           done_reg, done_next;
  logic           err_reg, err_next;

  logic [15:0] bcd_in;
  logic [3:0]  digit_bad;
  logic        bcd_bad;

  assign bcd_in = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_chk
      assign digit_bad[gi] = (bcd_in[4*gi+3 -: 4] > 4'd9);
    end
  endgenerate

  assign bcd_bad = (|digit_bad) || (bcd_in == 16'd0);

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  logic [15:0] trial;
  logic [14:0] diff;
  logic        ge;
  logic [19:0] quo_step;

  assign trial    = {rem_reg, quo_reg[19]};
  assign ge       = (trial >= {2'b00, bin_reg});
  assign diff     = trial[14:0] - {1'b0, bin_reg};
  assign quo_step = {quo_reg[18:0], ge};

  logic us_tick;
  assign us_tick = (us_reg == PW'(US_TICKS - 1));

  always_comb begin
    state_next  = state_reg;
    digits_next = digits_reg;
    bin_next    = bin_reg;
    cnt_next    = cnt_reg;
    rem_next    = rem_reg;
    quo_next    = quo_reg;
    prd_next    = prd_reg;
    half_next   = half_reg;
    us_next     = us_reg;
    hcnt_next   = hcnt_reg;
    sq_next     = sq_reg;
    done_next   = 1'b0;
    err_next    = err_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          digits_next = bcd_in;
          if (bcd_bad) begin
            err_next = 1'b1;
          end else begin
            err_next   = 1'b0;
            bin_next   = '0;
            cnt_next   = '0;
            state_next = CONV;
          end
        end
      end

      CONV: begin
        if (bus.stop) begin
          sq_next    = 1'b0;
          state_next = IDLE;
        end else begin
          bin_next    = bin_reg * 14'd10 + {10'd0, digits_reg[15:12]};
          digits_next = {digits_reg[11:0], 4'h0};
          cnt_next    = cnt_reg + 5'd1;
          if (cnt_reg == 5'd3) begin
            cnt_next   = '0;
            rem_next   = '0;
            quo_next   = DVND_W;
            state_next = DIV;
          end
        end
      end

      DIV: begin
        if (bus.stop) begin
          sq_next    = 1'b0;
          state_next = IDLE;
        end else begin
          rem_next = ge ? diff : trial[14:0];
          quo_next = quo_step;
          cnt_next = cnt_reg + 5'd1;
          if (cnt_reg == 5'd19) begin
            prd_next   = quo_step;
            half_next  = quo_step[19:1];
            us_next    = '0;
            hcnt_next  = '0;
            sq_next    = 1'b0;
            done_next  = 1'b1;
            state_next = RUN;
          end
        end
      end

      RUN: begin
        if (bus.stop) begin
          sq_next    = 1'b0;
          state_next = IDLE;
        end else if (bus.start && !bcd_bad) begin
          digits_next = bcd_in;
          err_next    = 1'b0;
          bin_next    = '0;
          cnt_next    = '0;
          sq_next     = 1'b0;
          state_next  = CONV;
        end else begin
          // A rejected retune only flags err; the current wave keeps running.
          if (bus.start) err_next = 1'b1;
          us_next = us_tick ? '0 : us_reg + 1'b1;
          if (us_tick) begin
            if (hcnt_reg == half_reg - 19'd1) begin
              hcnt_next = '0;
              sq_next   = ~sq_reg;
            end else begin
              hcnt_next = hcnt_reg + 19'd1;
            end
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      digits_reg <= '0;
      bin_reg    <= '0;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      quo_reg    <= '0;
      prd_reg    <= '0;
      half_reg   <= '0;
      us_reg     <= '0;
      hcnt_reg   <= '0;
      sq_reg     <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      digits_reg <= digits_next;
      bin_reg    <= bin_next;
      cnt_reg    <= cnt_next;
      rem_reg    <= rem_next;
      quo_reg    <= quo_next;
      prd_reg    <= prd_next;
      half_reg   <= half_next;
      us_reg     <= us_next;
      hcnt_reg   <= hcnt_next;
      sq_reg     <= sq_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  assign bus.sq_out    = sq_reg;
  assign bus.prd       = prd_reg;
  assign bus.ready     = (state_reg == IDLE) || (state_reg == RUN);
  assign bus.done_tick = done_reg;
  assign bus.err       = err_reg;

endmodule

// File: tb/tb_low_freq_gen.sv
// Directed bench for low_freq_gen with US_TICKS=1 so one us equals one clock.
// Table of BCD frequencies with hand-computed periods, plus stop/retune/reset sequences.
module tb_low_freq_gen;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  low_freq_gen_if bus();

  low_freq_gen #(.US_TICKS(1), .DVND(1_000_000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0]  d3, d2, d1, d0;
    logic        valid;
    logic [19:0] prd;
    int          half;
    logic        wave;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
  endtask

  // Pulse start for one cycle and count edges (the start edge is 1) until done_tick.
  task automatic do_start(input logic [3:0] d3, d2, d1, d0,
                          output int lat, output logic seen,
                          output logic sq_after, output logic rdy_after);
    @(negedge clk);
    bus.bcd3 = d3; bus.bcd2 = d2; bus.bcd1 = d1; bus.bcd0 = d0;
    bus.start = 1'b1;
    lat = 0;
    seen = 1'b0;
    sq_after = 1'b0;
    rdy_after = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      lat++;
      if (i == 0) begin
        sq_after  = bus.sq_out;
        rdy_after = bus.ready;
      end
      if (bus.done_tick) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_level(input logic lvl, input int limit, output int cnt);
    cnt = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (bus.sq_out === lvl) break;
    end
  endtask

  task automatic measure_wave(input int half, input string name);
    int cnt;
    wait_level(1'b1, half + 20, cnt);
    check({name, "_rise"}, cnt, half);
    wait_level(1'b0, half + 20, cnt);
    check({name, "_fall"}, cnt, half);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, cnt, ndone, nsq;
    logic seen, sq_after, rdy_after;

    //             d3    d2    d1    d0    valid  prd       half    wave
    vecs[0] = '{4'd0, 4'd0, 4'd5, 4'd0, 1'b1, 20'd20000,  10000, 1'b1};
    vecs[1] = '{4'd9, 4'd9, 4'd9, 4'd9, 1'b1, 20'd100,    50,    1'b1};
    vecs[2] = '{4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 20'd0,      0,     1'b0};
    vecs[3] = '{4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 20'd810,    405,   1'b1};
    vecs[4] = '{4'd0, 4'hA, 4'd0, 4'd0, 1'b0, 20'd0,      0,     1'b0};
    vecs[5] = '{4'd0, 4'd0, 4'd0, 4'd3, 1'b1, 20'd333333, 166666, 1'b0};
    vecs[6] = '{4'd0, 4'd0, 4'd0, 4'd1, 1'b1, 20'd1000000, 500000, 1'b0};
    vecs[7] = '{4'd0, 4'd0, 4'd0, 4'd7, 1'b1, 20'd142857, 71428, 1'b0};
    vecs[8] = '{4'd0, 4'd0, 4'd0, 4'hF, 1'b0, 20'd0,      0,     1'b0};
    vecs[9] = '{4'd1, 4'd0, 4'd0, 4'd0, 1'b1, 20'd1000,   500,   1'b1};

    reset = 1'b0;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.bcd3 = 4'd0; bus.bcd2 = 4'd0; bus.bcd1 = 4'd0; bus.bcd0 = 4'd0;
    #12;
    check("rst_sq_out", {31'd0, bus.sq_out}, 32'd0);
    check("rst_prd", {12'd0, bus.prd}, 32'd0);
    check("rst_ready", {31'd0, bus.ready}, 32'd1);
    check("rst_done", {31'd0, bus.done_tick}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int v = 0; v < 10; v++) begin
      go_idle();
      do_start(vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0, lat, seen, sq_after, rdy_after);
      $display("[TB] vec %0d bcd=%h%h%h%h valid=%0d lat=%0d prd=%0d err=%0d", v,
               vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0, vecs[v].valid, lat, bus.prd, bus.err);
      if (vecs[v].valid) begin
        check($sformatf("v%0d_busy", v), {31'd0, rdy_after}, 32'd0);
        check($sformatf("v%0d_latency", v), lat, 25);
        check($sformatf("v%0d_prd", v), {12'd0, bus.prd}, {12'd0, vecs[v].prd});
        check($sformatf("v%0d_err", v), {31'd0, bus.err}, 32'd0);
        check($sformatf("v%0d_ready", v), {31'd0, bus.ready}, 32'd1);
        check($sformatf("v%0d_sq0", v), {31'd0, bus.sq_out}, 32'd0);
        if (vecs[v].wave) measure_wave(vecs[v].half, $sformatf("v%0d_wave", v));
      end else begin
        check($sformatf("v%0d_no_done", v), {31'd0, seen}, 32'd0);
        check($sformatf("v%0d_err", v), {31'd0, bus.err}, 32'd1);
        check($sformatf("v%0d_ready", v), {31'd0, bus.ready}, 32'd1);
        check($sformatf("v%0d_sq", v), {31'd0, bus.sq_out}, 32'd0);
      end
    end

    // Stop on the 10th divide cycle: abort to idle, prd keeps 1000.
    go_idle();
    @(negedge clk);
    bus.bcd3 = 4'd9; bus.bcd2 = 4'd9; bus.bcd1 = 4'd9; bus.bcd0 = 4'd9;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (13) @(posedge clk);
    #1 bus.stop = 1'b1;
    @(posedge clk);
    #1 bus.stop = 1'b0;
    check("divstop_ready", {31'd0, bus.ready}, 32'd1);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_tick) ndone++;
    end
    check("divstop_no_done", ndone, 0);
    check("divstop_prd", {12'd0, bus.prd}, 32'd1000);
    check("divstop_sq", {31'd0, bus.sq_out}, 32'd0);
    $display("[TB] stop in div: ready=%0d prd=%0d done_count=%0d", bus.ready, bus.prd, ndone);

    // Start and stop together while running: stop wins, wave stays low.
    do_start(4'd9, 4'd9, 4'd9, 4'd9, lat, seen, sq_after, rdy_after);
    check("ss_latency", lat, 25);
    @(negedge clk);
    bus.bcd3 = 4'd1; bus.bcd2 = 4'd0; bus.bcd1 = 4'd0; bus.bcd0 = 4'd0;
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_ready", {31'd0, bus.ready}, 32'd1);
    ndone = 0;
    nsq = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #1;
      if (bus.done_tick) ndone++;
      if (bus.sq_out) nsq++;
    end
    check("ss_no_done", ndone, 0);
    check("ss_sq_low", nsq, 0);
    check("ss_prd", {12'd0, bus.prd}, 32'd100);
    $display("[TB] start+stop in run: done_count=%0d sq_high=%0d prd=%0d", ndone, nsq, bus.prd);

    // Retune from run while sq_out is high.
    do_start(4'd9, 4'd9, 4'd9, 4'd9, lat, seen, sq_after, rdy_after);
    wait_level(1'b1, 80, cnt);
    check("retune_pre_high", {31'd0, bus.sq_out}, 32'd1);
    do_start(4'd1, 4'd0, 4'd0, 4'd0, lat, seen, sq_after, rdy_after);
    check("retune_sq_forced0", {31'd0, sq_after}, 32'd0);
    check("retune_busy", {31'd0, rdy_after}, 32'd0);
    check("retune_latency", lat, 25);
    check("retune_prd", {12'd0, bus.prd}, 32'd1000);
    $display("[TB] retune to 1000 Hz: lat=%0d prd=%0d", lat, bus.prd);

    // Asynchronous reset in the middle of a high half-period.
    wait_level(1'b1, 600, cnt);
    check("rstrun_pre_high", {31'd0, bus.sq_out}, 32'd1);
    #3 reset = 1'b0;
    #1;
    check("rstrun_sq", {31'd0, bus.sq_out}, 32'd0);
    check("rstrun_prd", {12'd0, bus.prd}, 32'd0);
    check("rstrun_ready", {31'd0, bus.ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    do_start(4'd9, 4'd9, 4'd9, 4'd9, lat, seen, sq_after, rdy_after);
    check("rstrun_restart_latency", lat, 25);
    check("rstrun_restart_prd", {12'd0, bus.prd}, 32'd100);
    $display("[TB] reset mid-run then restart: lat=%0d prd=%0d", lat, bus.prd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
